// File: rtl/oram_setup_arbiter.sv
// Round-robin arbiter that merges several client channels onto one ORAM command port.
// Writes are gathered into FEDWidth words; read returns are unpacked and routed by an in-order tag FIFO.
module oram_setup_arbiter #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned FEDWidth    = 512,
  parameter int unsigned ORAMU       = 32,
  parameter int unsigned TagDepth    = 8
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [NumChannels-1:0]           ChCmdValid,
  output logic [NumChannels-1:0]           ChCmdReady,
  input  logic [NumChannels-1:0]           ChCmdRead,
  input  logic [NumChannels*ORAMU-1:0]     ChAddr,
  input  logic [NumChannels*DataWidth-1:0] ChDataIn,
  input  logic [NumChannels-1:0]           ChDataInValid,
  output logic [NumChannels-1:0]           ChDataInReady,
  output logic [DataWidth-1:0]             ChDataOut,
  output logic [NumChannels-1:0]           ChDataOutValid,
  input  logic [NumChannels-1:0]           ChDataOutReady,
  output logic [1:0]                       CmdORAM,
  output logic [ORAMU-1:0]                 PAddrORAM,
  output logic                             CmdValidORAM,
  input  logic                             CmdReadyORAM,
  output logic [FEDWidth-1:0]              DataInORAM,
  output logic                             DataInValidORAM,
  input  logic                             DataInReadyORAM,
  input  logic [FEDWidth-1:0]              DataOutORAM,
  input  logic                             DataOutValidORAM,
  output logic                             DataOutReadyORAM
);
  localparam int unsigned R   = FEDWidth / DataWidth;
  localparam int unsigned CW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned BW  = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned PW  = (TagDepth > 1) ? $clog2(TagDepth) : 1;
  localparam int unsigned TCW = $clog2(TagDepth + 1);

  typedef enum logic [1:0] {StIdle, StCmd, StGather, StPush} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       grant_q, grant_d;
  logic [CW-1:0]       last_q, last_d;
  logic [ORAMU-1:0]    addr_q, addr_d;
  logic                read_q, read_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [FEDWidth-1:0] word_q, word_d;

  logic [CW-1:0]       tag_mem_q [TagDepth];
  logic [CW-1:0]       tag_mem_d [TagDepth];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TCW-1:0]      tag_cnt_q, tag_cnt_d;
  logic                resp_busy_q, resp_busy_d;
  logic [BW-1:0]       resp_cnt_q, resp_cnt_d;
  logic [FEDWidth-1:0] resp_word_q, resp_word_d;

  logic                tag_push, tag_pop, found;
  logic [CW-1:0]       cand, win, head;

  assign CmdORAM    = {1'b0, read_q};
  assign PAddrORAM  = addr_q;
  assign DataInORAM = word_q;

  // Command FSM
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    addr_d        = addr_q;
    read_d        = read_q;
    beat_d        = beat_q;
    word_d        = word_q;
    tag_push      = 1'b0;
    found         = 1'b0;
    cand          = '0;
    win           = '0;
    ChCmdReady    = '0;
    ChDataInReady = '0;
    CmdValidORAM  = 1'b0;
    DataInValidORAM = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Registered tag count: a pop this cycle does not make a read eligible yet.
        for (int k = 1; k <= int'(NumChannels); k++) begin
          cand = CW'((int'(last_q) + k) % int'(NumChannels));
          if (!found && ChCmdValid[cand] &&
              (!ChCmdRead[cand] || (tag_cnt_q < TCW'(TagDepth)))) begin
            found = 1'b1;
            win   = cand;
          end
        end
        if (found) begin
          grant_d = win;
          addr_d  = ChAddr[int'(win)*ORAMU +: ORAMU];
          read_d  = ChCmdRead[win];
          state_d = StCmd;
        end
      end
      StCmd: begin
        CmdValidORAM = 1'b1;
        if (CmdReadyORAM) begin
          ChCmdReady[grant_q] = 1'b1;
          last_d = grant_q;
          if (read_q) begin
            tag_push = 1'b1;
            state_d  = StIdle;
          end else begin
            beat_d  = '0;
            state_d = StGather;
          end
        end
      end
      StGather: begin
        ChDataInReady[grant_q] = 1'b1;
        if (ChDataInValid[grant_q]) begin
          word_d[int'(beat_q)*DataWidth +: DataWidth] =
            ChDataIn[int'(grant_q)*DataWidth +: DataWidth];
          if (beat_q == BW'(R - 1)) begin
            state_d = StPush;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      StPush: begin
        DataInValidORAM = 1'b1;
        if (DataInReadyORAM) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Response path and tag FIFO
  always_comb begin
    head             = tag_mem_q[rd_ptr_q];
    DataOutReadyORAM = !resp_busy_q && (tag_cnt_q != '0);
    ChDataOutValid   = '0;
    if (resp_busy_q) begin
      ChDataOutValid[head] = 1'b1;
    end
    ChDataOut   = resp_word_q[int'(resp_cnt_q)*DataWidth +: DataWidth];
    resp_busy_d = resp_busy_q;
    resp_cnt_d  = resp_cnt_q;
    resp_word_d = resp_word_q;
    tag_pop     = 1'b0;
    if (DataOutValidORAM && DataOutReadyORAM) begin
      resp_word_d = DataOutORAM;
      resp_busy_d = 1'b1;
      resp_cnt_d  = '0;
    end else if (resp_busy_q && ChDataOutReady[head]) begin
      if (resp_cnt_q == BW'(R - 1)) begin
        tag_pop     = 1'b1;
        resp_busy_d = 1'b0;
      end else begin
        resp_cnt_d = resp_cnt_q + BW'(1);
      end
    end

    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_cnt_d = tag_cnt_q;
    if (tag_push) begin
      tag_mem_d[wr_ptr_q] = grant_q;
      wr_ptr_d = (wr_ptr_q == PW'(TagDepth - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (tag_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(TagDepth - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    if (tag_push && !tag_pop) begin
      tag_cnt_d = tag_cnt_q + TCW'(1);
    end else if (!tag_push && tag_pop) begin
      tag_cnt_d = tag_cnt_q - TCW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      last_q      <= CW'(NumChannels - 1);
      addr_q      <= '0;
      read_q      <= 1'b0;
      beat_q      <= '0;
      word_q      <= '0;
      tag_mem_q   <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tag_cnt_q   <= '0;
      resp_busy_q <= 1'b0;
      resp_cnt_q  <= '0;
      resp_word_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      beat_q      <= beat_d;
      word_q      <= word_d;
      tag_mem_q   <= tag_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_cnt_q   <= tag_cnt_d;
      resp_busy_q <= resp_busy_d;
      resp_cnt_q  <= resp_cnt_d;
      resp_word_q <= resp_word_d;
    end
  end

endmodule

// File: tb/tb_oram_setup_arbiter.sv
// Scoreboard bench for oram_setup_arbiter: directed client/ORAM traffic, expectations queued
// at issue time and checked by a negedge monitor.
module tb_oram_setup_arbiter;
  localparam int NC = 4;
  localparam int DW = 64;
  localparam int FW = 512;
  localparam int AW = 32;
  localparam int TD = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   ch_cmd_valid, ch_cmd_ready, ch_cmd_read;
  logic [NC*AW-1:0] ch_addr;
  logic [NC*DW-1:0] ch_din;
  logic [NC-1:0]   ch_din_valid, ch_din_ready;
  logic [DW-1:0]   ch_dout;
  logic [NC-1:0]   ch_dout_valid, ch_dout_ready;
  logic [1:0]      cmd_oram;
  logic [AW-1:0]   paddr;
  logic            cmd_valid, cmd_ready;
  logic [FW-1:0]   din_oram;
  logic            din_valid, din_ready;
  logic [FW-1:0]   dout_oram;
  logic            dout_valid, dout_ready;

  oram_setup_arbiter #(
    .NumChannels(NC), .DataWidth(DW), .FEDWidth(FW), .ORAMU(AW), .TagDepth(TD)
  ) dut (
    .Clock(clk), .Reset(rst_n),
    .ChCmdValid(ch_cmd_valid), .ChCmdReady(ch_cmd_ready), .ChCmdRead(ch_cmd_read),
    .ChAddr(ch_addr), .ChDataIn(ch_din), .ChDataInValid(ch_din_valid),
    .ChDataInReady(ch_din_ready), .ChDataOut(ch_dout), .ChDataOutValid(ch_dout_valid),
    .ChDataOutReady(ch_dout_ready), .CmdORAM(cmd_oram), .PAddrORAM(paddr),
    .CmdValidORAM(cmd_valid), .CmdReadyORAM(cmd_ready), .DataInORAM(din_oram),
    .DataInValidORAM(din_valid), .DataInReadyORAM(din_ready), .DataOutORAM(dout_oram),
    .DataOutValidORAM(dout_valid), .DataOutReadyORAM(dout_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] ch; logic rd; logic [AW-1:0] addr; } cmd_t;
  typedef struct packed { logic [1:0] ch; logic [DW-1:0] data; } beat_t;
  cmd_t          exp_cmd_q[$];
  logic [FW-1:0] exp_word_q[$];
  beat_t         exp_beat_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got nothing expected an event", name);
  endtask

  function automatic logic [DW-1:0] wr_beat(input int ch, input int n, input int b);
    return {8'hD0, 8'(ch), 8'(n), 8'(b), 32'h0BEE_F000};
  endfunction

  function automatic logic [FW-1:0] wr_word(input int ch, input int n);
    logic [FW-1:0] w;
    for (int b = 0; b < FW / DW; b++) w[b*DW +: DW] = wr_beat(ch, n, b);
    return w;
  endfunction

  function automatic logic [DW-1:0] rd_beat(input int w, input int b);
    return {8'hE0, 8'(w), 40'h0, 8'(b)};
  endfunction

  // Pushes the expected return beats for word w routed to ch and returns the ORAM word.
  function automatic logic [FW-1:0] rd_word(input int w, input int ch);
    logic [FW-1:0] x;
    beat_t e;
    for (int b = 0; b < FW / DW; b++) begin
      x[b*DW +: DW] = rd_beat(w, b);
      e.ch = 2'(ch);
      e.data = rd_beat(w, b);
      exp_beat_q.push_back(e);
    end
    return x;
  endfunction

  function automatic void exp_cmd(input int ch, input logic rd, input logic [AW-1:0] addr);
    cmd_t c;
    c.ch = 2'(ch);
    c.rd = rd;
    c.addr = addr;
    exp_cmd_q.push_back(c);
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) fail_msg("cmd_unexpected");
        else begin
          cmd_t e;
          e = exp_cmd_q.pop_front();
          check("cmd_addr", FW'(paddr), FW'(e.addr));
          check("cmd_type", FW'(cmd_oram), FW'({1'b0, e.rd}));
          check("cmd_ready_onehot", FW'(ch_cmd_ready), FW'(4'b1 << e.ch));
        end
      end else if (ch_cmd_ready != '0) begin
        check("cmd_ready_without_handshake", FW'(ch_cmd_ready), '0);
      end
      if (ch_din_ready != '0) check("din_ready_onehot", FW'($countones(ch_din_ready)), FW'(1));
      if (din_valid && din_ready) begin
        if (exp_word_q.size() == 0) fail_msg("word_unexpected");
        else check("write_word", din_oram, exp_word_q.pop_front());
      end
      if (ch_dout_valid != '0) begin
        if (exp_beat_q.size() == 0) fail_msg("beat_unexpected");
        else begin
          beat_t b;
          b = exp_beat_q[0];
          check("dout_valid_route", FW'(ch_dout_valid), FW'(4'b1 << b.ch));
          check("dout_data", FW'(ch_dout), FW'(b.data));
          check("oram_rdy_while_busy", FW'(dout_ready), '0);
          if ((ch_dout_valid & ch_dout_ready) != '0) void'(exp_beat_q.pop_front());
        end
      end
    end
  end

  task automatic wait_grant(input int ch);
    int t = 0;
    do begin @(negedge clk); t++; end while (!ch_cmd_ready[ch] && t < 300);
    if (!ch_cmd_ready[ch]) fail_msg("cmd_grant_timeout");
    @(posedge clk); #1;
    ch_cmd_valid[ch] = 1'b0;
  endtask

  task automatic write_req(input int ch, input logic [AW-1:0] addr, input int n,
                           input int nbeats, input int gap);
    int t;
    ch_addr[ch*AW +: AW] = addr;
    ch_cmd_read[ch] = 1'b0;
    ch_cmd_valid[ch] = 1'b1;
    wait_grant(ch);
    for (int b = 0; b < nbeats; b++) begin
      repeat (gap) begin @(posedge clk); #1; end
      ch_din[ch*DW +: DW] = wr_beat(ch, n, b);
      ch_din_valid[ch] = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!ch_din_ready[ch] && t < 300);
      if (!ch_din_ready[ch]) fail_msg("beat_accept_timeout");
      @(posedge clk); #1;
      ch_din_valid[ch] = 1'b0;
    end
  endtask

  task automatic read_req(input int ch, input logic [AW-1:0] addr);
    ch_addr[ch*AW +: AW] = addr;
    ch_cmd_read[ch] = 1'b1;
    ch_cmd_valid[ch] = 1'b1;
    wait_grant(ch);
  endtask

  task automatic oram_return(input logic [FW-1:0] w);
    int t = 0;
    dout_oram = w;
    dout_valid = 1'b1;
    do begin @(negedge clk); t++; end while (!dout_ready && t < 300);
    if (!dout_ready) fail_msg("oram_return_timeout");
    @(posedge clk); #1;
    dout_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cmd_ready"}, FW'(ch_cmd_ready), '0);
    check({tag, "_din_ready"}, FW'(ch_din_ready), '0);
    check({tag, "_dout_valid"}, FW'(ch_dout_valid), '0);
    check({tag, "_dout"}, FW'(ch_dout), '0);
    check({tag, "_cmd_oram"}, FW'({cmd_oram, cmd_valid, din_valid, dout_ready}), '0);
    check({tag, "_paddr"}, FW'(paddr), '0);
    check({tag, "_din_oram"}, din_oram, '0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] w;
    int t;
    ch_cmd_valid = '0; ch_cmd_read = '0; ch_addr = '0; ch_din = '0; ch_din_valid = '0;
    ch_dout_ready = '1; cmd_ready = 1'b1; din_ready = 1'b1; dout_oram = '0; dout_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Four writers contend; channel 0 comes back for a second write.
    exp_cmd(0, 1'b0, 32'h1000); exp_cmd(1, 1'b0, 32'h1100); exp_cmd(2, 1'b0, 32'h1200);
    exp_cmd(3, 1'b0, 32'h1300); exp_cmd(0, 1'b0, 32'h1008);
    exp_word_q.push_back(wr_word(0, 0)); exp_word_q.push_back(wr_word(1, 0));
    exp_word_q.push_back(wr_word(2, 0)); exp_word_q.push_back(wr_word(3, 0));
    exp_word_q.push_back(wr_word(0, 1));
    fork
      begin write_req(0, 32'h1000, 0, 8, 0); write_req(0, 32'h1008, 1, 8, 0); end
      write_req(1, 32'h1100, 0, 8, 0);
      write_req(2, 32'h1200, 0, 8, 0);
      write_req(3, 32'h1300, 0, 8, 0);
    join
    repeat (5) @(posedge clk); #1;

    // Channel 2 read of 0x40; beat b = 0x0102 + b*0x1010.
    exp_cmd(2, 1'b1, 32'h40);
    for (int b = 0; b < 8; b++) begin
      beat_t e;
      e.ch = 2'd2;
      e.data = 64'h0102 + 64'(b) * 64'h1010;
      w[b*DW +: DW] = e.data;
      exp_beat_q.push_back(e);
    end
    fork
      read_req(2, 32'h40);
      begin repeat (4) @(posedge clk); #1; oram_return(w); end
    join
    repeat (12) @(posedge clk); #1;
    check("read_fully_drained", FW'(exp_beat_q.size()), '0);

    // Tag FIFO full: third read from channel 1 stalls until the first word drains.
    exp_cmd(1, 1'b1, 32'h100); exp_cmd(1, 1'b1, 32'h104); exp_cmd(1, 1'b1, 32'h108);
    fork
      begin read_req(1, 32'h100); read_req(1, 32'h104); read_req(1, 32'h108); end
      begin
        repeat (20) @(negedge clk);
        check("third_read_stalled", FW'(exp_cmd_q.size()), FW'(1));
        @(posedge clk); #1;
        oram_return(rd_word(1, 1));
        void'(rd_word(2, 1));
        void'(rd_word(3, 1));
        t = 0;
        do begin @(negedge clk); t++; end while (exp_beat_q.size() > 16 && t < 40);
        check("stall_until_drain", FW'(exp_cmd_q.size()), FW'(1));
        repeat (3) @(negedge clk);
        check("stall_released", FW'(exp_cmd_q.size()), '0);
        @(posedge clk); #1;
        w = '0;
        for (int b = 0; b < 8; b++) w[b*DW +: DW] = rd_beat(2, b);
        oram_return(w);
        for (int b = 0; b < 8; b++) w[b*DW +: DW] = rd_beat(3, b);
        oram_return(w);
      end
    join
    repeat (15) @(posedge clk); #1;
    check("stall_reads_drained", FW'(exp_beat_q.size()), '0);

    // Channel 3 read returns while channel 0 is gathering a slow write.
    exp_cmd(3, 1'b1, 32'h300); exp_cmd(0, 1'b0, 32'h2000);
    exp_word_q.push_back(wr_word(0, 2));
    w = rd_word(4, 3);
    read_req(3, 32'h300);
    fork
      write_req(0, 32'h2000, 2, 8, 2);
      begin repeat (8) @(posedge clk); #1; oram_return(w); end
    join
    repeat (10) @(posedge clk); #1;

    // Channel 2 read drained with ready toggling 1010...
    exp_cmd(2, 1'b1, 32'h80);
    w = rd_word(5, 2);
    fork
      read_req(2, 32'h80);
      begin repeat (3) @(posedge clk); #1; oram_return(w); end
      begin
        for (int i = 0; i < 40; i++) begin
          ch_dout_ready[2] = (i % 2 == 0);
          @(posedge clk); #1;
        end
        ch_dout_ready[2] = 1'b1;
      end
    join
    repeat (5) @(posedge clk); #1;
    check("toggle_read_drained", FW'(exp_beat_q.size()), '0);

    // Reset in the middle of a gather, then a clean write from beat 0.
    exp_cmd(1, 1'b0, 32'h3000);
    write_req(1, 32'h3000, 3, 3, 0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cmd(1, 1'b0, 32'h3100);
    exp_word_q.push_back(wr_word(1, 4));
    write_req(1, 32'h3100, 4, 8, 0);

    repeat (20) @(posedge clk); #1;
    check("end_cmd_queue", FW'(exp_cmd_q.size()), '0);
    check("end_word_queue", FW'(exp_word_q.size()), '0);
    check("end_beat_queue", FW'(exp_beat_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
